tiled_matmul_accum_unit: RTL and testbench
==========================================

// Module: tiled_matmul_accum_unit
// PURPOSE
//  Computes C = A x B (optionally C += A x B) for signed MxK by KxN matrices with LANES parallel MAC lanes.
//  Each lane produces one output column; for each row it walks the columns in groups of LANES, over K cycles.
//  Post-processing per element: arithmetic right shift, then saturate or truncate to OUT_WIDTH. Optional B transpose.
//  Sits in the transformer datapath as the next-generation matmul engine: projections, scores, FFN.
// PARAMETERS
//  DATA_WIDTH   8   signed element width of A and B
//  ACCUM_WIDTH  32  accumulator width; must be >= 2*DATA_WIDTH + clog2(K_DIM)
//  OUT_WIDTH    16  signed width of each C output element
//  M_DIM        4   rows of A and C
//  K_DIM        3   cols of A / rows of B
//  N_DIM        2   cols of B and C
//  LANES        2   parallel MAC lanes, 1..N_DIM; G = ceil(N_DIM/LANES) column groups
// PORTS
//  clk              in   1                     clock
//  rst_n            in   1                     async active-low reset
//  op_start         in   1                     start request; acted on at rising edge (registered edge detect)
//  op_abort         in   1                     sync abort; returns to IDLE next cycle, no done pulse
//  mode_accum       in   1                     1: C_acc += A*B, 0: C_acc = A*B
//  mode_transpose_b in   1                     1: matrix_b_in holds B^T (NxK, row-major)
//  shift_amt        in   $clog2(ACCUM_WIDTH)   arithmetic right shift applied before output
//  sat_en           in   1                     1: saturate to OUT_WIDTH, 0: keep low OUT_WIDTH bits
//  matrix_a_in      in   M*K*DATA_WIDTH        row-major, element [m][k] at bits (m*K+k)*DATA_WIDTH
//  matrix_b_in      in   K*N*DATA_WIDTH        row-major KxN (or NxK if transposed)
//  c_out            out  M*N*OUT_WIDTH         registered results, row-major
//  op_busy          out  1                     high from LATCH through the last WRITE
//  op_done          out  1                     one-cycle pulse in the DONE state
//  sat_flag         out  1                     at least one element clipped in the last op (sat_en=1 only)
// BEHAVIOUR
//  Reset: state IDLE. c_out, acc_mem, latched A/B/modes, counters, op_busy, op_done and sat_flag are all 0.
//  FSM: IDLE -(start edge)-> LATCH -> MAC (K cycles) -> WRITE -> {MAC for the next (m,g) | DONE} -> IDLE.
//  LATCH (1 cycle): register A, B, mode bits, shift_amt, sat_en; clear m, g and k counters; clear sat_flag.
//  MAC state, k = 0..K-1:
//   - Each lane l handles col n = g*LANES+l: acc_l += A[m][k]*B[k][n] (uses B[n][k] when transposed).
//   - At k=0 the lane base is acc_mem[m][n] if mode_accum, else 0.
//   - Lanes with n >= N_DIM are disabled; their results are never written.
//  WRITE (1 cycle): for every valid lane, acc_mem[m][n] <= acc_l and c_out[m][n] <= post(acc_l).
//   Then advance g; on wrap advance m. After m=M-1, g=G-1 go to DONE.
//  Arithmetic:
//   - Product is full 2*DATA_WIDTH signed, sign-extended; accumulation wraps mod 2^ACCUM_WIDTH.
//   - post(x) = x >>> shift_amt; if sat_en, clip to [-2^(OUT-1), 2^(OUT-1)-1] and set sat_flag on clip.
//   - If not sat_en, take the low OUT_WIDTH bits; sat_flag is unchanged.
//  Latency: start edge sampled at cycle t -> op_done high at t+2+M*G*(K+1); op_busy low in IDLE and DONE.
//  c_out holds all values between ops; partially updated rows stay visible after an abort.
//  Edge cases:
//   - Start edges arriving while busy or in DONE are ignored, not queued.
//   - op_start held high does not retrigger.
//   - Abort in any non-IDLE state: IDLE next cycle. acc_mem keeps the rows already written.
//   - Reset mid-op clears everything asynchronously.
//  Input stability: inputs only need to be stable in the LATCH cycle.
// STRUCTURE
//  Package matmul_pkg:
//   - state typedef (IDLE, LATCH, MAC, WRITE, DONE)
//   - function sat_shift(acc, shift, sat_en) -> {clipped, value}
//   - localparam helpers for G and counter widths
//  Sub-module mac_lane (DATA/ACCUM params; inputs load_en, load_val, mac_en, a, b; output acc), instantiated LANES times.
//  Top level holds the FSM, counters, operand selection/transpose muxing, acc_mem and c_out.
// TESTING
//  1 Defaults, A=[[1,2,3],[4,5,6],[7,8,9],[-1,-2,-3]], B=[[1,2],[3,4],[5,6]], shift 0, sat on
//    -> C=[[22,28],[49,64],[76,100],[-22,-28]]; op_done at t+18.
//  2 Repeat test 1 with mode_accum=1 -> C=[[44,56],[98,128],[152,200],[-44,-56]].
//  3 Test 1, mode_transpose_b=1, B^T=[[1,3,5],[2,4,6]] -> same C as test 1.
//    Test 1 with shift_amt=2 -> C[0]=[5,7], C[3]=[-6,-7].
//  4 A all 127, B all -128, sat_en=1 -> every C = -32768, sat_flag=1.
//    Same with sat_en=0 -> every C = 16768, sat_flag=0.
//  5 LANES=1 build, test 1 stimulus -> same C; op_done at t+34.
//  6 Extra start edge while busy -> ignored, single done.
//    op_abort at cycle t+6 -> IDLE next cycle, no done, row 0 of C written.
//    rst_n low mid-op -> all outputs 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the tiled matmul engine: FSM states, sizing
// helpers and the shift/saturate post-processing function.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Post-processing runs at a fixed wide width so one function serves any accumulator width
    localparam int POST_W = 64;

    function automatic int num_groups(input int n_dim, input int lanes);
        return (n_dim + lanes - 32'sd1) / lanes;
    endfunction

    function automatic int cnt_w(input int count);
        return (count > 32'sd1) ? $clog2(count) : 32'sd1;
    endfunction

    // Returns {clipped, value}; value is the arithmetic-shifted accumulator,
    // clipped to the signed out_w range when sat_en is set.
    function automatic logic [POST_W:0] sat_shift(
        input logic signed [POST_W-1:0] acc,
        input logic        [5:0]        shift,
        input logic                     sat_en,
        input int                       out_w
    );
        logic signed [POST_W-1:0] shifted;
        logic signed [POST_W-1:0] max_v;
        logic signed [POST_W-1:0] min_v;
        logic signed [POST_W-1:0] value;
        logic                     clipped;
        shifted = acc >>> shift;
        max_v   = (64'sd1 <<< (out_w - 32'sd1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        if (sat_en) begin
            if (shifted > max_v) begin
                clipped = 1'b1;
                value   = max_v;
            end else if (shifted < min_v) begin
                clipped = 1'b1;
                value   = min_v;
            end else begin
                clipped = 1'b0;
                value   = shifted;
            end
        end else begin
            clipped = 1'b0;
            value   = shifted;
        end
        return {clipped, value};
    endfunction

endpackage

// File: rtl/tiled_matmul_accum_unit_mac_lane.sv
// One multiply-accumulate lane: optionally reloads a base value and adds the
// sign-extended full-width product each enabled cycle, wrapping on overflow.
module mac_lane #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [ACCUM_WIDTH-1:0]        load_val,
    input  logic                          mac_en,
    input  logic signed [DATA_WIDTH-1:0]  a,
    input  logic signed [DATA_WIDTH-1:0]  b,
    output logic [ACCUM_WIDTH-1:0]        acc
);

    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic [ACCUM_WIDTH-1:0]         prod_ext_s;
    logic [ACCUM_WIDTH-1:0]         base_s;
    logic [ACCUM_WIDTH-1:0]         acc_r;

    // Product, sign extension and choice of accumulation base
    always_comb begin
        prod_s     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        prod_ext_s = {{(ACCUM_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
        if (load_en) begin
            base_s = load_val;
        end else begin
            base_s = acc_r;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (mac_en) begin
            acc_r <= base_s + prod_ext_s;
        end else if (load_en) begin
            acc_r <= load_val;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/tiled_matmul_accum_unit.sv
// Tiled signed matrix multiply / accumulate engine: C (+)= A x B using LANES
// parallel MAC lanes, one output column per lane, K cycles per (row, group).
module tiled_matmul_accum_unit
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int M_DIM       = 4,
    parameter int K_DIM       = 3,
    parameter int N_DIM       = 2,
    parameter int LANES       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 op_start,
    input  logic                                 op_abort,
    input  logic                                 mode_accum,
    input  logic                                 mode_transpose_b,
    input  logic [$clog2(ACCUM_WIDTH)-1:0]       shift_amt,
    input  logic                                 sat_en,
    input  logic [M_DIM*K_DIM*DATA_WIDTH-1:0]    matrix_a_in,
    input  logic [K_DIM*N_DIM*DATA_WIDTH-1:0]    matrix_b_in,
    output logic [M_DIM*N_DIM*OUT_WIDTH-1:0]     c_out,
    output logic                                 op_busy,
    output logic                                 op_done,
    output logic                                 sat_flag
);

    localparam int G_DIM   = num_groups(N_DIM, LANES);
    localparam int M_W     = cnt_w(M_DIM);
    localparam int K_W     = cnt_w(K_DIM);
    localparam int G_W     = cnt_w(G_DIM);
    localparam int SHIFT_W = $clog2(ACCUM_WIDTH);
    localparam int C_IDX_W = cnt_w(M_DIM*N_DIM);
    localparam int A_IDX_W = cnt_w(M_DIM*K_DIM);
    localparam int B_IDX_W = cnt_w(K_DIM*N_DIM);
    localparam logic [M_W-1:0] M_LAST = M_W'(M_DIM - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K_DIM - 1);
    localparam logic [G_W-1:0] G_LAST = G_W'(G_DIM - 1);

    state_t                        state_r, next_s;
    logic                          start_r, start_d_r, start_edge_s;
    logic                          op_busy_r, op_done_r, sat_flag_r;
    logic [M_W-1:0]                m_r;
    logic [G_W-1:0]                g_r;
    logic [K_W-1:0]                k_r;
    logic signed [DATA_WIDTH-1:0]  a_mat_r [M_DIM*K_DIM];
    logic signed [DATA_WIDTH-1:0]  b_mat_r [K_DIM*N_DIM];
    logic                          accum_r, transpose_r, sat_en_r;
    logic [SHIFT_W-1:0]            shift_r;
    logic [ACCUM_WIDTH-1:0]        acc_mem_r [M_DIM*N_DIM];
    logic [OUT_WIDTH-1:0]          c_out_r [M_DIM*N_DIM];

    logic [A_IDX_W-1:0]            a_idx_s;
    logic signed [DATA_WIDTH-1:0]  a_sel_s;
    logic                          load_en_s, mac_en_s, sat_any_s, unused_post_s;
    logic                          lane_valid_s [LANES];
    logic [C_IDX_W-1:0]            lane_idx_s   [LANES];
    logic signed [DATA_WIDTH-1:0]  lane_b_s     [LANES];
    logic [ACCUM_WIDTH-1:0]        lane_base_s  [LANES];
    logic [ACCUM_WIDTH-1:0]        lane_acc_s   [LANES];
    logic [POST_W:0]               lane_res_s   [LANES];
    logic [OUT_WIDTH-1:0]          lane_post_s  [LANES];

    assign start_edge_s = start_r & ~start_d_r;

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_edge_s) next_s = ST_LATCH; else next_s = ST_IDLE;
            ST_LATCH: if (op_abort) next_s = ST_IDLE; else next_s = ST_MAC;
            ST_MAC: begin
                if (op_abort)           next_s = ST_IDLE;
                else if (k_r == K_LAST) next_s = ST_WRITE;
                else                    next_s = ST_MAC;
            end
            ST_WRITE: begin
                if (op_abort)                               next_s = ST_IDLE;
                else if ((m_r == M_LAST) && (g_r == G_LAST)) next_s = ST_DONE;
                else                                        next_s = ST_MAC;
            end
            ST_DONE:  next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // State register, start edge detector and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            start_r   <= 1'b0;
            start_d_r <= 1'b0;
            op_busy_r <= 1'b0;
            op_done_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            start_r   <= op_start;
            start_d_r <= start_r;
            op_busy_r <= (next_s == ST_LATCH) || (next_s == ST_MAC) || (next_s == ST_WRITE);
            op_done_r <= (next_s == ST_DONE);
        end
    end

    // Operand selection (with optional B transpose), lane bases and post-processing
    always_comb begin
        int n_col;
        logic [B_IDX_W-1:0] b_idx;
        a_idx_s       = A_IDX_W'(32'(m_r) * K_DIM + 32'(k_r));
        a_sel_s       = a_mat_r[a_idx_s];
        load_en_s     = (state_r == ST_MAC) && (k_r == '0);
        mac_en_s      = (state_r == ST_MAC);
        sat_any_s     = 1'b0;
        unused_post_s = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            n_col           = 32'(g_r) * LANES + l;
            lane_valid_s[l] = (n_col < N_DIM);
            if (lane_valid_s[l]) begin
                lane_idx_s[l] = C_IDX_W'(32'(m_r) * N_DIM + n_col);
                if (transpose_r) begin
                    b_idx = B_IDX_W'(n_col * K_DIM + 32'(k_r));
                end else begin
                    b_idx = B_IDX_W'(32'(k_r) * N_DIM + n_col);
                end
            end else begin
                lane_idx_s[l] = '0;
                b_idx         = '0;
            end
            lane_b_s[l]    = b_mat_r[b_idx];
            lane_base_s[l] = accum_r ? acc_mem_r[lane_idx_s[l]] : '0;
            lane_res_s[l]  = sat_shift({{(POST_W-ACCUM_WIDTH){lane_acc_s[l][ACCUM_WIDTH-1]}}, lane_acc_s[l]},
                                       6'(shift_r), sat_en_r, OUT_WIDTH);
            lane_post_s[l] = lane_res_s[l][OUT_WIDTH-1:0];
            sat_any_s      = sat_any_s | (lane_valid_s[l] & lane_res_s[l][POST_W]);
            unused_post_s  = unused_post_s ^ (^lane_res_s[l][POST_W-1:OUT_WIDTH]);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ACCUM_WIDTH (ACCUM_WIDTH)
        ) u_mac_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (load_en_s),
            .load_val (lane_base_s[l]),
            .mac_en   (mac_en_s),
            .a        (a_sel_s),
            .b        (lane_b_s[l]),
            .acc      (lane_acc_s[l])
        );
    end

    // Operand/mode latch, tile counters, result write-back and clip flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M_DIM*K_DIM; i++) a_mat_r[i] <= '0;
            for (int i = 0; i < K_DIM*N_DIM; i++) b_mat_r[i] <= '0;
            for (int i = 0; i < M_DIM*N_DIM; i++) begin
                acc_mem_r[i] <= '0;
                c_out_r[i]   <= '0;
            end
            accum_r     <= 1'b0;
            transpose_r <= 1'b0;
            sat_en_r    <= 1'b0;
            shift_r     <= '0;
            m_r         <= '0;
            g_r         <= '0;
            k_r         <= '0;
            sat_flag_r  <= 1'b0;
        end else if (state_r == ST_LATCH) begin
            for (int i = 0; i < M_DIM*K_DIM; i++) a_mat_r[i] <= matrix_a_in[i*DATA_WIDTH +: DATA_WIDTH];
            for (int i = 0; i < K_DIM*N_DIM; i++) b_mat_r[i] <= matrix_b_in[i*DATA_WIDTH +: DATA_WIDTH];
            accum_r     <= mode_accum;
            transpose_r <= mode_transpose_b;
            sat_en_r    <= sat_en;
            shift_r     <= shift_amt;
            m_r         <= '0;
            g_r         <= '0;
            k_r         <= '0;
            sat_flag_r  <= 1'b0;
        end else if (state_r == ST_MAC) begin
            k_r <= (k_r == K_LAST) ? '0 : k_r + K_W'(1);
        end else if (state_r == ST_WRITE) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_valid_s[l]) begin
                    acc_mem_r[lane_idx_s[l]] <= lane_acc_s[l];
                    c_out_r[lane_idx_s[l]]   <= lane_post_s[l];
                end
            end
            if (sat_en_r && sat_any_s) sat_flag_r <= 1'b1;
            if (g_r == G_LAST) begin
                g_r <= '0;
                m_r <= m_r + M_W'(1);
            end else begin
                g_r <= g_r + G_W'(1);
            end
        end else begin
            k_r <= k_r;
        end
    end

    for (genvar i = 0; i < M_DIM*N_DIM; i++) begin : g_cout
        assign c_out[i*OUT_WIDTH +: OUT_WIDTH] = c_out_r[i];
    end

    assign op_busy  = op_busy_r;
    assign op_done  = op_done_r;
    assign sat_flag = sat_flag_r;

endmodule

// File: tb/tb_tiled_matmul_accum_unit.sv
// Directed bench for tiled_matmul_accum_unit: default 2-lane build plus a
// LANES=1 build sharing the same stimulus.
module tb_tiled_matmul_accum_unit;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int M  = 4;
    localparam int K  = 3;
    localparam int N  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               op_start = 1'b0;
    logic               op_abort = 1'b0;
    logic               mode_accum = 1'b0;
    logic               mode_transpose_b = 1'b0;
    logic [4:0]         shift_amt = 5'd0;
    logic               sat_en = 1'b1;
    logic [M*K*DW-1:0]  matrix_a_in = '0;
    logic [K*N*DW-1:0]  matrix_b_in = '0;
    logic [M*N*OW-1:0]  c_out, c_out_l1;
    logic               op_busy, op_done, sat_flag;
    logic               op_busy_l1, op_done_l1, sat_flag_l1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int av[12];
    int bv[6];
    int cv[8];
    logic [M*N*OW-1:0] exp_c;

    tiled_matmul_accum_unit #(.LANES(2)) dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .op_abort(op_abort),
        .mode_accum(mode_accum), .mode_transpose_b(mode_transpose_b),
        .shift_amt(shift_amt), .sat_en(sat_en),
        .matrix_a_in(matrix_a_in), .matrix_b_in(matrix_b_in),
        .c_out(c_out), .op_busy(op_busy), .op_done(op_done), .sat_flag(sat_flag)
    );

    tiled_matmul_accum_unit #(.LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .op_abort(op_abort),
        .mode_accum(mode_accum), .mode_transpose_b(mode_transpose_b),
        .shift_amt(shift_amt), .sat_en(sat_en),
        .matrix_a_in(matrix_a_in), .matrix_b_in(matrix_b_in),
        .c_out(c_out_l1), .op_busy(op_busy_l1), .op_done(op_done_l1), .sat_flag(sat_flag_l1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter: after posedge e, cyc == e
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [M*K*DW-1:0] pack_a(input int v[12]);
        logic [M*K*DW-1:0] r;
        for (int i = 0; i < 12; i++) r[i*DW +: DW] = 8'(v[i]);
        return r;
    endfunction

    function automatic logic [K*N*DW-1:0] pack_b(input int v[6]);
        logic [K*N*DW-1:0] r;
        for (int i = 0; i < 6; i++) r[i*DW +: DW] = 8'(v[i]);
        return r;
    endfunction

    function automatic logic [M*N*OW-1:0] pack_c(input int v[8]);
        logic [M*N*OW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*OW +: OW] = 16'(v[i]);
        return r;
    endfunction

    task automatic set_defaults();
        av = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, -2, -3};
        bv = '{1, 2, 3, 4, 5, 6};
        matrix_a_in      = pack_a(av);
        matrix_b_in      = pack_b(bv);
        mode_accum       = 1'b0;
        mode_transpose_b = 1'b0;
        shift_amt        = 5'd0;
        sat_en           = 1'b1;
    endtask

    // Pulses start (sampled at edge t0) and waits, bounded, for op_done of the 2-lane build
    task automatic run_op(output int lat, output logic busy_mid, output logic done_after);
        int t0;
        int n;
        @(negedge clk);
        op_start = 1'b1;
        t0 = cyc + 1;
        busy_mid = 1'b0;
        @(negedge clk);
        op_start = 1'b0;
        n = 0;
        while (op_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (cyc == t0 + 2) busy_mid = op_busy;
        end
        lat = (op_done === 1'b1) ? cyc - t0 : -1;
        @(negedge clk);
        done_after = op_done;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (c_out !== '0)     begin errors++; $display("FAIL reset_c_out: got %h expected 0", c_out); end
        checks++; if (op_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", op_busy); end
        checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", op_done); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic busy_mid, done_after;
        set_defaults();
        run_op(lat, busy_mid, done_after);
        cv = '{22, 28, 49, 64, 76, 100, -22, -28};
        exp_c = pack_c(cv);
        checks++; if (lat !== 18)          begin errors++; $display("FAIL basic_latency: got %0d expected 18", lat); end
        checks++; if (busy_mid !== 1'b1)   begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (c_out !== exp_c)     begin errors++; $display("FAIL basic_c: got %h expected %h", c_out, exp_c); end
        checks++; if (sat_flag !== 1'b0)   begin errors++; $display("FAIL basic_sat_flag: got %b expected 0", sat_flag); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done_after); end
        checks++; if (op_busy !== 1'b0)    begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", op_busy); end
    endtask

    task automatic test_accum();
        int lat; logic busy_mid, done_after;
        set_defaults();
        mode_accum = 1'b1;
        run_op(lat, busy_mid, done_after);
        cv = '{44, 56, 98, 128, 152, 200, -44, -56};
        exp_c = pack_c(cv);
        checks++; if (c_out !== exp_c) begin errors++; $display("FAIL accum_c: got %h expected %h", c_out, exp_c); end
        checks++; if (lat !== 18)      begin errors++; $display("FAIL accum_latency: got %0d expected 18", lat); end
    endtask

    task automatic test_transpose_shift();
        int lat; logic busy_mid, done_after;
        set_defaults();
        mode_transpose_b = 1'b1;
        bv = '{1, 3, 5, 2, 4, 6};
        matrix_b_in = pack_b(bv);
        run_op(lat, busy_mid, done_after);
        cv = '{22, 28, 49, 64, 76, 100, -22, -28};
        exp_c = pack_c(cv);
        checks++; if (c_out !== exp_c) begin errors++; $display("FAIL transpose_c: got %h expected %h", c_out, exp_c); end
        set_defaults();
        shift_amt = 5'd2;
        run_op(lat, busy_mid, done_after);
        cv = '{5, 7, 12, 16, 19, 25, -6, -7};
        exp_c = pack_c(cv);
        checks++; if (c_out !== exp_c) begin errors++; $display("FAIL shift_c: got %h expected %h", c_out, exp_c); end
    endtask

    task automatic test_saturate();
        int lat; logic busy_mid, done_after;
        set_defaults();
        av = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
        bv = '{-128, -128, -128, -128, -128, -128};
        matrix_a_in = pack_a(av);
        matrix_b_in = pack_b(bv);
        run_op(lat, busy_mid, done_after);
        cv = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        exp_c = pack_c(cv);
        checks++; if (c_out !== exp_c)   begin errors++; $display("FAIL sat_c: got %h expected %h", c_out, exp_c); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
        sat_en = 1'b0;
        run_op(lat, busy_mid, done_after);
        cv = '{16768, 16768, 16768, 16768, 16768, 16768, 16768, 16768};
        exp_c = pack_c(cv);
        checks++; if (c_out !== exp_c)   begin errors++; $display("FAIL trunc_c: got %h expected %h", c_out, exp_c); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL trunc_sat_flag: got %b expected 0", sat_flag); end
    endtask

    task automatic test_single_lane();
        int t0; int n; int lat;
        set_defaults();
        n = 0;
        while ((op_busy_l1 !== 1'b0 || op_done_l1 !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        op_start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        op_start = 1'b0;
        n = 0;
        while (op_done_l1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = (op_done_l1 === 1'b1) ? cyc - t0 : -1;
        cv = '{22, 28, 49, 64, 76, 100, -22, -28};
        exp_c = pack_c(cv);
        checks++; if (lat !== 34)         begin errors++; $display("FAIL lanes1_latency: got %0d expected 34", lat); end
        checks++; if (c_out_l1 !== exp_c) begin errors++; $display("FAIL lanes1_c: got %h expected %h", c_out_l1, exp_c); end
    endtask

    task automatic test_back_to_back();
        int t0; int done_cnt; int first_done;
        set_defaults();
        repeat (40) @(negedge clk);
        op_start = 1'b1;
        t0 = cyc + 1;
        done_cnt = 0;
        first_done = -1;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            if (cyc == t0) op_start = 1'b0;
            if (cyc == t0 + 4) op_start = 1'b1;
            if (op_done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc - t0;
            end
        end
        op_start = 1'b0;
        checks++; if (done_cnt !== 1)    begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
        checks++; if (first_done !== 18) begin errors++; $display("FAIL b2b_latency: got %0d expected 18", first_done); end
    endtask

    task automatic test_abort();
        int t0; int done_cnt;
        set_defaults();
        av = '{2, 4, 6, 4, 5, 6, 7, 8, 9, -1, -2, -3};
        matrix_a_in = pack_a(av);
        @(negedge clk);
        op_start = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cyc == t0) op_start = 1'b0;
            if (cyc == t0 + 6) op_abort = 1'b1;
        end
        op_abort = 1'b0;
        checks++; if (op_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", op_busy); end
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (op_done === 1'b1) done_cnt++;
        end
        cv = '{44, 56, 49, 64, 76, 100, -22, -28};
        exp_c = pack_c(cv);
        checks++; if (done_cnt !== 0)  begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        checks++; if (c_out !== exp_c) begin errors++; $display("FAIL abort_c: got %h expected %h", c_out, exp_c); end
    endtask

    task automatic test_reset_mid_op();
        int t0;
        set_defaults();
        av = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
        bv = '{-128, -128, -128, -128, -128, -128};
        matrix_a_in = pack_a(av);
        matrix_b_in = pack_b(bv);
        repeat (40) @(negedge clk);
        op_start = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (cyc == t0) op_start = 1'b0;
        end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL rstmid_pre_flag: got %b expected 1", sat_flag); end
        rst_n = 1'b0;
        #1;
        checks++; if (c_out !== '0)      begin errors++; $display("FAIL rstmid_c: got %h expected 0", c_out); end
        checks++; if (c_out_l1 !== '0)   begin errors++; $display("FAIL rstmid_c_l1: got %h expected 0", c_out_l1); end
        checks++; if (op_busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", op_busy); end
        checks++; if (op_done !== 1'b0)  begin errors++; $display("FAIL rstmid_done: got %b expected 0", op_done); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL rstmid_flag: got %b expected 0", sat_flag); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_basic();
        test_accum();
        test_transpose_shift();
        test_saturate();
        test_single_lane();
        test_back_to_back();
        test_abort();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
